a0_trace_buffer: RTL

//  Sits directly downstream of the CPU top and consumes its a0 output (data_out).

---
 rtl/a0_trace_buffer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/a0_trace_buffer.sv
// a0_trace_buffer
// Watches the CPU's a0 value and records every change as a {timestamp, value}
// entry in a first-word-fall-through FIFO. The host drains entries through a
// valid/ready port. The very first enabled sample after reset is always
// recorded, so the initial a0 value is captured as well.
module a0_trace_buffer #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int TSW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              data_i,
    input  logic                       en_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DW-1:0]              out_data_o,
    output logic [TSW-1:0]             out_ts_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   prev_q;
    logic [TSW-1:0]  ts_q, ts_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    // Entry storage; no reset needed since the outputs are masked when empty.
    logic [DW-1:0]   mem_data_q [DEPTH];
    logic [TSW-1:0]  mem_ts_q   [DEPTH];

    logic empty;
    logic full;
    logic push_req;
    logic push;
    logic pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Change detection: the first enabled sample after reset always records;
    // afterwards only a differing value does.
    always_comb begin
        push_req = 1'b0;
        if (en_i) begin
            if (state_q == IDLE) begin
                push_req = 1'b1;
            end else begin
                push_req = (data_i != prev_q);
            end
        end
    end

    // A pop in the same cycle frees the slot the push needs, so a full FIFO
    // still accepts a new entry when the head is being consumed.
    assign pop  = !empty && out_ready_i;
    assign push = push_req && (!full || pop);

    // Next-state for timestamp, pointers, occupancy and the sticky drop flag.
    always_comb begin
        ts_d       = ts_q + TSW'(1);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        overflow_d = overflow_q || (push_req && !push);
    end

    // Capture FSM: IDLE until the first enabled sample, then ARMED until reset.
    // prev follows every recorded change, including ones dropped on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
        end else if (en_i) begin
            state_q <= ARMED;
            if (push_req) begin
                prev_q <= data_i;
            end
        end
    end

    // Timestamp counter, FIFO pointers, occupancy and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry write; the timestamp stored is that of the sampling cycle.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= data_i;
            mem_ts_q[wr_ptr_q]   <= ts_q;
        end
    end

    // Head entry is presented combinationally and zeroed while empty.
    assign out_valid_o = !empty;
    assign out_data_o  = empty ? '0 : mem_data_q[rd_ptr_q];
    assign out_ts_o    = empty ? '0 : mem_ts_q[rd_ptr_q];
    assign count_o     = count_q;
    assign full_o      = full;
    assign overflow_o  = overflow_q;

endmodule
